decode_stage_fwd: RTL

Parametrised decode stage with a built-in register file, N-source priority operand forwarding, load-use interlock, and a registered ID/EX output behind a valid/ready handshake. It sits between fetch and execute in the pipelined core. It replaces fixed 4-way hazard muxing with a generic youngest-first forwarding network and adds stall, bubble and flush behaviour. The control word and immediate come from the existing combinational decoders; this block owns operand selection and the pipeline register.

---
 rtl/decode_stage_fwd_pkg.sv | 51 +++++
 rtl/decode_stage_fwd_if.sv | 62 ++++++
 rtl/decode_stage_fwd_regfile.sv | 49 ++++
 rtl/decode_stage_fwd.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_fwd_pkg.sv
// Shared definitions for the decode stage: default sizes, address-width helper,
// operand-source encoding and control-word field offsets consumed by execute.
package decode_stage_fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NFWD_DEF = 3;
  localparam int CW_W_DEF = 28;

  // Register-address fields inside the 32-bit instruction word
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int RD_LSB      = 7;
  localparam int REG_FIELD_W = 5;

  // Control word field offsets, as laid out by the decoder and read by execute
  localparam int CW_ALU_OP_LSB = 0;
  localparam int CW_ALU_OP_W   = 4;
  localparam int CW_SRC_B_IMM  = 4;
  localparam int CW_SRC_A_PC   = 5;
  localparam int CW_MEM_RD     = 6;
  localparam int CW_MEM_WR     = 7;
  localparam int CW_MEM_SZ_LSB = 8;
  localparam int CW_MEM_SZ_W   = 2;
  localparam int CW_MEM_UNS    = 10;
  localparam int CW_REG_WE     = 11;
  localparam int CW_WB_SEL_LSB = 12;
  localparam int CW_WB_SEL_W   = 2;
  localparam int CW_BRANCH     = 14;
  localparam int CW_BR_OP_LSB  = 15;
  localparam int CW_BR_OP_W    = 3;
  localparam int CW_JUMP       = 18;
  localparam int CW_JALR       = 19;
  localparam int CW_CSR_LSB    = 20;
  localparam int CW_CSR_W      = 3;
  localparam int CW_ILLEGAL    = 23;
  localparam int CW_SYSTEM     = 24;
  localparam int CW_FENCE      = 25;

  typedef enum logic [1:0] {
    OP_SRC_ZERO = 2'd0,
    OP_SRC_FWD  = 2'd1,
    OP_SRC_WB   = 2'd2,
    OP_SRC_RF   = 2'd3
  } op_src_e;

  function automatic int aw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decode_stage_fwd_if.sv
// Fetch/forwarding/writeback inputs and ID/EX outputs of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface decode_stage_fwd_if
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NFWD = NFWD_DEF,
  parameter int CW_W = CW_W_DEF
);
  localparam int AW = aw_f(NREG);

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pc_plus_4;
  logic [CW_W-1:0]      ctrl;
  logic [XLEN-1:0]      imm;
  logic                 use_rs1;
  logic                 use_rs2;

  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*AW-1:0]   fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_ready;

  logic                 wb_we;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;
  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_a;
  logic [XLEN-1:0]      out_b;
  logic [XLEN-1:0]      out_imm;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_pc_plus_4;
  logic [CW_W-1:0]      out_ctrl;
  logic [AW-1:0]        out_rs1;
  logic [AW-1:0]        out_rs2;
  logic [AW-1:0]        out_rd;
  logic [31:0]          stall_cnt;

  modport master (
    output in_valid, instr, pc, pc_plus_4, ctrl, imm, use_rs1, use_rs2,
    output fwd_valid, fwd_rd, fwd_data, fwd_ready,
    output wb_we, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_imm, out_pc, out_pc_plus_4,
    input  out_ctrl, out_rs1, out_rs2, out_rd, stall_cnt
  );

  modport slave (
    input  in_valid, instr, pc, pc_plus_4, ctrl, imm, use_rs1, use_rs2,
    input  fwd_valid, fwd_rd, fwd_data, fwd_ready,
    input  wb_we, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_imm, out_pc, out_pc_plus_4,
    output out_ctrl, out_rs1, out_rs2, out_rd, stall_cnt
  );

endinterface

// File: rtl/decode_stage_fwd_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port; x0 is hardwired to zero.
module regfile_2r1w
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = aw_f(NREG)
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents; entry 0 is forced back to zero every cycle
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/decode_stage_fwd.sv
// Decode stage: operand resolution with youngest-first forwarding, load-use
// interlock, writeback bypass and the registered ID/EX valid/ready stage.
module decode_stage_fwd
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NFWD = NFWD_DEF,
  parameter int CW_W = CW_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  decode_stage_fwd_if.slave bus
);

  localparam int AW = aw_f(NREG);

  typedef struct packed {
    logic            haz;
    op_src_e         src;
    logic [XLEN-1:0] fwd_val;
  } op_sel_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [CW_W-1:0] ctrl;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
  } idex_t;

  logic [AW-1:0]   rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] rf_rd1_s, rf_rd2_s;
  logic [XLEN-1:0] op_a_s, op_b_s;
  op_sel_t         sel1_s, sel2_s;
  logic            hazard_s, advance_s, accept_s, stall_evt_s;
  logic            unused_s;

  logic            out_valid_q, out_valid_d;
  idex_t           pay_q, pay_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  // Youngest-first scan: the first matching source wins; a match that is not
  // ready yet stalls rather than falling through to older data.
  function automatic op_sel_t resolve_f(
    input logic [AW-1:0]        rs,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD*AW-1:0]   frd,
    input logic [NFWD*XLEN-1:0] fd,
    input logic [NFWD-1:0]      frdy,
    input logic                 we,
    input logic [AW-1:0]        wa
  );
    op_sel_t r;
    logic    hit;
    logic    sel_v;
    r.haz     = 1'b0;
    r.src     = OP_SRC_RF;
    r.fwd_val = '0;
    hit       = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      sel_v     = !hit && fv[i] && (frd[i*AW +: AW] == rs);
      r.haz     = sel_v ? !frdy[i] : r.haz;
      r.fwd_val = sel_v ? fd[i*XLEN +: XLEN] : r.fwd_val;
      hit       = hit || sel_v;
    end
    if (rs == '0) begin
      r.src = OP_SRC_ZERO;
      r.haz = 1'b0;
    end else if (hit) begin
      r.src = OP_SRC_FWD;
    end else if (we && (wa == rs)) begin
      r.src = OP_SRC_WB;
    end else begin
      r.src = OP_SRC_RF;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] op_mux_f(
    input op_sel_t         sel,
    input logic [XLEN-1:0] wb,
    input logic [XLEN-1:0] rf
  );
    logic [XLEN-1:0] v;
    case (sel.src)
      OP_SRC_ZERO: v = '0;
      OP_SRC_FWD:  v = sel.fwd_val;
      OP_SRC_WB:   v = wb;
      OP_SRC_RF:   v = rf;
      default:     v = '0;
    endcase
    return v;
  endfunction

  assign unused_s = ^{bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};

  // Register addresses; an unused operand reads x0
  always_comb begin
    rs1_s = bus.use_rs1 ? AW'(bus.instr[RS1_LSB +: REG_FIELD_W]) : '0;
    rs2_s = bus.use_rs2 ? AW'(bus.instr[RS2_LSB +: REG_FIELD_W]) : '0;
    rd_s  = AW'(bus.instr[RD_LSB +: REG_FIELD_W]);
  end

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst),
    .we     (bus.wb_we),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .rdata1 (rf_rd1_s),
    .rdata2 (rf_rd2_s)
  );

  // Operand selection and handshake qualifiers
  always_comb begin
    sel1_s = resolve_f(rs1_s, bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                       bus.fwd_ready, bus.wb_we, bus.wb_addr);
    sel2_s = resolve_f(rs2_s, bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                       bus.fwd_ready, bus.wb_we, bus.wb_addr);
    op_a_s      = op_mux_f(sel1_s, bus.wb_data, rf_rd1_s);
    op_b_s      = op_mux_f(sel2_s, bus.wb_data, rf_rd2_s);
    hazard_s    = sel1_s.haz || sel2_s.haz;
    advance_s   = !out_valid_q || bus.out_ready;
    accept_s    = advance_s && bus.in_valid && !hazard_s && !bus.flush;
    stall_evt_s = bus.in_valid && hazard_s && !bus.flush;
  end

  assign bus.in_ready = (advance_s && !hazard_s) || bus.flush;

  // Next ID/EX contents and stall counter
  always_comb begin
    out_valid_d = out_valid_q;
    pay_d       = pay_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (advance_s) begin
      out_valid_d = accept_s;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      pay_d.a         = op_a_s;
      pay_d.b         = op_b_s;
      pay_d.imm       = bus.imm;
      pay_d.pc        = bus.pc;
      pay_d.pc_plus_4 = bus.pc_plus_4;
      pay_d.ctrl      = bus.ctrl;
      pay_d.rs1       = rs1_s;
      pay_d.rs2       = rs2_s;
      pay_d.rd        = rd_s;
    end else begin
      pay_d = pay_q;
    end
    if (stall_evt_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      pay_q       <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      pay_q       <= pay_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_a         = pay_q.a;
  assign bus.out_b         = pay_q.b;
  assign bus.out_imm       = pay_q.imm;
  assign bus.out_pc        = pay_q.pc;
  assign bus.out_pc_plus_4 = pay_q.pc_plus_4;
  assign bus.out_ctrl      = pay_q.ctrl;
  assign bus.out_rs1       = pay_q.rs1;
  assign bus.out_rs2       = pay_q.rs2;
  assign bus.out_rd        = pay_q.rd;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule
